// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine controller: FSM encodings,
// error codes, coin denominations, the price table and the greedy coin pick.
package vending_pkg;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_CREDIT = 2'd1;
    localparam state_t S_VEND   = 2'd2;
    localparam state_t S_CHANGE = 2'd3;

    // err_code values; ERR_NONE whenever err is low
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_CODE  = 2'b01;
    localparam logic [1:0] ERR_SOLD_OUT  = 2'b10;
    localparam logic [1:0] ERR_NO_CREDIT = 2'b11;

    // Change denominations, largest first
    localparam int unsigned DENOM_50 = 50;
    localparam int unsigned DENOM_10 = 10;
    localparam int unsigned DENOM_5  = 5;
    localparam int unsigned DENOM_1  = 1;

    // Price of an item code; 0 for codes outside the table
    function automatic int unsigned price(input int unsigned code);
        case (code)
            1:       return 10;
            2:       return 15;
            3:       return 25;
            4:       return 40;
            5:       return 55;
            6:       return 70;
            7:       return 90;
            8:       return 120;
            9:       return 150;
            10:      return 200;
            default: return 0;
        endcase
    endfunction

    // Largest denomination not exceeding amt; 0 when nothing is owed
    function automatic int unsigned largest_coin(input int unsigned amt);
        if (amt >= DENOM_50)      return DENOM_50;
        else if (amt >= DENOM_10) return DENOM_10;
        else if (amt >= DENOM_5)  return DENOM_5;
        else if (amt >= DENOM_1)  return DENOM_1;
        else                      return 0;
    endfunction

endpackage

// File: rtl/vending_machine_ctrl_change_dispenser.sv
// Change payout: offers one coin at a time to the hopper, keeps it stable
// until accepted, and reports the credit left after each accepted coin.
// The offer for the next cycle is computed from the controller's next
// credit so a new coin is presented on the cycle after each acceptance.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,          // controller is in CHANGE next cycle
    input  logic [AMT_W-1:0] amt_d_i,         // controller credit next cycle
    input  logic [AMT_W-1:0] credit_i,        // controller credit this cycle
    input  logic             change_ready_i,
    output logic             pay_o,           // a coin is handed over this cycle
    output logic [AMT_W-1:0] credit_after_o,  // credit once the offered coin leaves
    output logic             change_valid_o,
    output logic [AMT_W-1:0] change_coin_o
);

    logic             valid_q, valid_d;
    logic [AMT_W-1:0] coin_q, coin_d;

    // Next offer: greedy coin for whatever is still owed
    always_comb begin
        valid_d = load_i && (amt_d_i != '0);
        coin_d  = '0;
        if (valid_d) coin_d = AMT_W'(largest_coin(32'(amt_d_i)));
    end

    // Offer registers; coin stays put while unaccepted because credit does
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            coin_q  <= '0;
        end else begin
            valid_q <= valid_d;
            coin_q  <= coin_d;
        end
    end

    assign pay_o          = valid_q && change_ready_i;
    assign credit_after_o = credit_i - coin_q;
    assign change_valid_o = valid_q;
    assign change_coin_o  = coin_q;

endmodule

// File: rtl/vending_machine_ctrl.sv
// Vending machine controller: credit accumulation, selection checking
// against price and stock, one-cycle vend pulse and change payout.
// Every output comes straight from a register.
module vending_machine_ctrl
    import vending_pkg::*;
#(
    parameter int AMT_W      = 8,
    parameter int NUM_ITEMS  = 10,
    parameter int CODE_W     = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              coin_valid_i,
    input  logic [AMT_W-1:0]  coin_value_i,
    input  logic              select_valid_i,
    input  logic [CODE_W-1:0] item_code_i,
    input  logic              cancel_i,
    input  logic              restock_valid_i,
    input  logic [CODE_W-1:0] restock_code_i,
    input  logic              change_ready_i,
    output logic [AMT_W-1:0]  credit_o,
    output logic              dispense_o,
    output logic [CODE_W-1:0] dispense_code_o,
    output logic              change_valid_o,
    output logic [AMT_W-1:0]  change_coin_o,
    output logic              coin_reject_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              busy_o
);

    state_t                              state_q, state_d;
    logic [AMT_W-1:0]                    credit_q, credit_d;
    logic [NUM_ITEMS:1][STOCK_W-1:0]     stock_q, stock_d;
    logic                                dispense_q, dispense_d;
    logic [CODE_W-1:0]                   disp_code_q, disp_code_d;
    logic                                reject_q, reject_d;
    logic                                err_q, err_d;
    logic [1:0]                          err_code_q, err_code_d;
    logic                                busy_q;

    logic [AMT_W:0]                      coin_sum;
    logic                                code_ok;
    logic [STOCK_W-1:0]                  sel_stock;
    int unsigned                         sel_price;
    logic                                vend_take;
    logic                                pay;
    logic [AMT_W-1:0]                    credit_after;

    // Carry bit of the sum flags a coin that would overflow the credit
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value_i};
    assign code_ok   = (item_code_i != '0) && (32'(item_code_i) <= 32'(NUM_ITEMS));
    assign sel_price = price(32'(item_code_i));

    // Stock of the selected slot (0 for out-of-range codes, caught by code_ok)
    always_comb begin
        sel_stock = '0;
        for (int i = 1; i <= NUM_ITEMS; i++) begin
            if (item_code_i == CODE_W'(i)) sel_stock = stock_q[i];
        end
    end

    // Main FSM: cancel beats select beats coin; losers of that race are rejected
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        dispense_d  = 1'b0;
        disp_code_d = disp_code_q;
        reject_d    = 1'b0;
        err_d       = 1'b0;
        err_code_d  = ERR_NONE;
        vend_take   = 1'b0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel_i) begin
                    reject_d = coin_valid_i;
                    if (state_q == S_CREDIT) state_d = S_CHANGE;
                end else if (select_valid_i) begin
                    reject_d = coin_valid_i;
                    if (!code_ok) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_CODE;
                    end else if (sel_stock == '0) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SOLD_OUT;
                    end else if (32'(credit_q) < sel_price) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NO_CREDIT;
                    end else begin
                        state_d     = S_VEND;
                        credit_d    = credit_q - AMT_W'(sel_price);
                        vend_take   = 1'b1;
                        dispense_d  = 1'b1;
                        disp_code_d = item_code_i;
                    end
                end else if (coin_valid_i) begin
                    if (coin_sum[AMT_W]) begin
                        reject_d = 1'b1;
                    end else if (coin_value_i != '0) begin
                        credit_d = coin_sum[AMT_W-1:0];
                        state_d  = S_CREDIT;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_valid_i;
                state_d  = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            default: begin  // S_CHANGE: selects ignored, coins bounced
                reject_d = coin_valid_i;
                if (pay) begin
                    credit_d = credit_after;
                    if (credit_after == '0) state_d = S_IDLE;
                end
            end
        endcase
    end

    // Stock update: vend takes one, restock fills the slot and wins a tie
    always_comb begin
        stock_d = stock_q;
        for (int i = 1; i <= NUM_ITEMS; i++) begin
            if (vend_take && item_code_i == CODE_W'(i))
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            if (restock_valid_i && restock_code_i == CODE_W'(i))
                stock_d[i] = '1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            stock_q     <= {NUM_ITEMS{STOCK_W'(INIT_STOCK)}};
            dispense_q  <= 1'b0;
            disp_code_q <= '0;
            reject_q    <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            stock_q     <= stock_d;
            dispense_q  <= dispense_d;
            disp_code_q <= disp_code_d;
            reject_q    <= reject_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            busy_q      <= (state_d == S_VEND) || (state_d == S_CHANGE);
        end
    end

    change_dispenser #(.AMT_W(AMT_W)) u_change (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .load_i         (state_d == S_CHANGE),
        .amt_d_i        (credit_d),
        .credit_i       (credit_q),
        .change_ready_i (change_ready_i),
        .pay_o          (pay),
        .credit_after_o (credit_after),
        .change_valid_o (change_valid_o),
        .change_coin_o  (change_coin_o)
    );

    assign credit_o        = credit_q;
    assign dispense_o      = dispense_q;
    assign dispense_code_o = disp_code_q;
    assign coin_reject_o   = reject_q;
    assign err_o           = err_q;
    assign err_code_o      = err_code_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Scenario bench for vending_machine_ctrl. Each scenario pushes the events it
// expects (vends, errors, change coins, coin rejects) onto queues; a monitor
// on the falling edge pops and compares as the DUT produces them.
module tb_vending_machine_ctrl;

    localparam int AMT_W  = 8;
    localparam int CODE_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              coin_valid = 1'b0;
    logic [AMT_W-1:0]  coin_value = '0;
    logic              select_valid = 1'b0;
    logic [CODE_W-1:0] item_code = '0;
    logic              cancel = 1'b0;
    logic              restock_valid = 1'b0;
    logic [CODE_W-1:0] restock_code = '0;
    logic              change_ready = 1'b0;
    logic [AMT_W-1:0]  credit;
    logic              dispense;
    logic [CODE_W-1:0] dispense_code;
    logic              change_valid;
    logic [AMT_W-1:0]  change_coin;
    logic              coin_reject;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int exp_disp_q[$];
    int exp_err_q[$];
    int exp_chg_q[$];
    int exp_rej_q[$];
    int m_e;

    vending_machine_ctrl dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .coin_valid_i    (coin_valid),
        .coin_value_i    (coin_value),
        .select_valid_i  (select_valid),
        .item_code_i     (item_code),
        .cancel_i        (cancel),
        .restock_valid_i (restock_valid),
        .restock_code_i  (restock_code),
        .change_ready_i  (change_ready),
        .credit_o        (credit),
        .dispense_o      (dispense),
        .dispense_code_o (dispense_code),
        .change_valid_o  (change_valid),
        .change_coin_o   (change_coin),
        .coin_reject_o   (coin_reject),
        .err_o           (err),
        .err_code_o      (err_code),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every DUT event must match the next expected one
    always @(negedge clk) begin
        if (rst_n) begin
            if (dispense) begin
                total++;
                if (exp_disp_q.size() == 0) begin
                    bad++; $display("FAIL disp_unexpected: got code %0d, none expected", dispense_code);
                end else begin
                    m_e = exp_disp_q.pop_front();
                    if (dispense_code !== CODE_W'(m_e)) begin
                        bad++; $display("FAIL disp_code: got %0d want %0d", dispense_code, m_e);
                    end
                end
            end
            if (err) begin
                total++;
                if (exp_err_q.size() == 0) begin
                    bad++; $display("FAIL err_unexpected: got err_code %0d, none expected", err_code);
                end else begin
                    m_e = exp_err_q.pop_front();
                    if (err_code !== 2'(m_e)) begin
                        bad++; $display("FAIL err_code: got %0d want %0d", err_code, m_e);
                    end
                end
            end else begin
                total++;
                if (err_code !== 2'b00) begin
                    bad++; $display("FAIL err_code_idle: got %0d want 0", err_code);
                end
            end
            if (change_valid && change_ready) begin
                total++;
                if (exp_chg_q.size() == 0) begin
                    bad++; $display("FAIL chg_unexpected: got coin %0d, none expected", change_coin);
                end else begin
                    m_e = exp_chg_q.pop_front();
                    if (change_coin !== AMT_W'(m_e)) begin
                        bad++; $display("FAIL chg_coin: got %0d want %0d", change_coin, m_e);
                    end
                end
            end
            if (coin_reject) begin
                total++;
                if (exp_rej_q.size() == 0) begin
                    bad++; $display("FAIL reject_unexpected: got coin_reject, none expected");
                end else begin
                    m_e = exp_rej_q.pop_front();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic put_coin(input int v, input bit rej);
        coin_valid = 1'b1; coin_value = AMT_W'(v);
        if (rej) exp_rej_q.push_back(1);
        tick();
        coin_valid = 1'b0; coin_value = '0;
    endtask

    task automatic do_sel(input int code, input bit is_err, input int ecode);
        if (is_err) exp_err_q.push_back(ecode);
        else        exp_disp_q.push_back(code);
        select_valid = 1'b1; item_code = CODE_W'(code);
        tick();
        select_valid = 1'b0; item_code = '0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Bounded wait for the machine to go quiet, then every expectation must be consumed
    task automatic settle(input string name);
        int n;
        for (n = 0; n < 80; n++) begin
            @(negedge clk); #1;
            if (!busy) break;
        end
        total++;
        if (busy !== 1'b0 || exp_disp_q.size() != 0 || exp_err_q.size() != 0 ||
            exp_chg_q.size() != 0 || exp_rej_q.size() != 0) begin
            bad++;
            $display("FAIL %s_settle: busy=%0b pending disp=%0d err=%0d chg=%0d rej=%0d, want all 0",
                     name, busy, exp_disp_q.size(), exp_err_q.size(), exp_chg_q.size(), exp_rej_q.size());
            exp_disp_q.delete(); exp_err_q.delete(); exp_chg_q.delete(); exp_rej_q.delete();
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({credit, dispense, dispense_code, change_valid, change_coin, coin_reject, err, err_code, busy} !== 27'd0) begin
            bad++; $display("FAIL reset_init: got credit=%0d cv=%0b busy=%0b, want all 0", credit, change_valid, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        put_coin(40, 1'b0);
        total++;
        if (credit !== 8'd40) begin bad++; $display("FAIL reset_pre_credit: got %0d want 40", credit); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({credit, dispense, dispense_code, change_valid, change_coin, coin_reject, err, err_code, busy} !== 27'd0) begin
            bad++; $display("FAIL reset_async: got credit=%0d busy=%0b, want all 0", credit, busy);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_exact_vend();
        put_coin(10, 1'b0);
        put_coin(5, 1'b0);
        total++;
        if (credit !== 8'd15) begin bad++; $display("FAIL exact_credit: got %0d want 15", credit); end
        do_sel(2, 1'b0, 0);
        total++;
        if (credit !== 8'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL exact_vend: got credit=%0d busy=%0b want 0/1", credit, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || change_valid !== 1'b0) begin
            bad++; $display("FAIL exact_idle: got busy=%0b change_valid=%0b want 0/0", busy, change_valid);
        end
        settle("exact");
    endtask

    task automatic test_change();
        change_ready = 1'b1;
        put_coin(50, 1'b0); put_coin(50, 1'b0); put_coin(50, 1'b0); put_coin(5, 1'b0);
        total++;
        if (credit !== 8'd155) begin bad++; $display("FAIL change_credit: got %0d want 155", credit); end
        exp_chg_q.push_back(10); exp_chg_q.push_back(10); exp_chg_q.push_back(10); exp_chg_q.push_back(5);
        do_sel(8, 1'b0, 0);
        total++;
        if (credit !== 8'd35) begin bad++; $display("FAIL change_vend_credit: got %0d want 35", credit); end
        settle("change");
        total++;
        if (credit !== 8'd0 || dispense_code !== 4'd8) begin
            bad++; $display("FAIL change_end: got credit=%0d code=%0d want 0/8", credit, dispense_code);
        end
        change_ready = 1'b0;
    endtask

    task automatic test_errors();
        for (int i = 0; i < 5; i++) put_coin(50, 1'b0);
        put_coin(10, 1'b1);
        total++;
        if (credit !== 8'd250) begin bad++; $display("FAIL err_overflow_credit: got %0d want 250", credit); end
        put_coin(5, 1'b0);
        total++;
        if (credit !== 8'd255) begin bad++; $display("FAIL err_max_credit: got %0d want 255", credit); end
        put_coin(1, 1'b1);
        do_sel(0, 1'b1, 1);
        do_sel(11, 1'b1, 1);
        total++;
        if (credit !== 8'd255) begin bad++; $display("FAIL err_badcode_credit: got %0d want 255", credit); end
        change_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_chg_q.push_back(50);
        exp_chg_q.push_back(5);
        do_cancel();
        settle("err_refund");
        put_coin(50, 1'b0); put_coin(50, 1'b0);
        do_sel(9, 1'b1, 3);
        total++;
        if (credit !== 8'd100) begin bad++; $display("FAIL err_nocredit_credit: got %0d want 100", credit); end
        exp_chg_q.push_back(50); exp_chg_q.push_back(10);
        do_sel(4, 1'b0, 0);
        settle("err_vend4");
        total++;
        if (credit !== 8'd0) begin bad++; $display("FAIL err_final_credit: got %0d want 0", credit); end
        change_ready = 1'b0;
    endtask

    task automatic test_stock_reset();
        for (int i = 0; i < 3; i++) begin
            put_coin(25, 1'b0);
            do_sel(3, 1'b0, 0);
            settle("stock_vend");
        end
        put_coin(25, 1'b0);
        do_sel(3, 1'b1, 2);
        settle("stock_soldout");
        total++;
        if (credit !== 8'd25) begin bad++; $display("FAIL stock_soldout_credit: got %0d want 25", credit); end
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        total++;
        if (credit !== 8'd0) begin bad++; $display("FAIL stock_reset_credit: got %0d want 0", credit); end
        put_coin(25, 1'b0);
        do_sel(3, 1'b0, 0);
        settle("stock_after_reset");
    endtask

    task automatic test_restock();
        for (int i = 0; i < 3; i++) begin
            put_coin(10, 1'b0);
            do_sel(1, 1'b0, 0);
            settle("restock_vend");
        end
        put_coin(10, 1'b0);
        do_sel(1, 1'b1, 2);
        restock_valid = 1'b1; restock_code = 4'd1;
        tick();
        restock_valid = 1'b0; restock_code = '0;
        do_sel(1, 1'b0, 0);
        settle("restock_refill");
        total++;
        if (credit !== 8'd0) begin bad++; $display("FAIL restock_credit: got %0d want 0", credit); end
        // Restock and vend of slot 5 together: slot ends full, so 3 more vends succeed
        put_coin(55, 1'b0);
        exp_disp_q.push_back(5);
        select_valid = 1'b1; item_code = 4'd5; restock_valid = 1'b1; restock_code = 4'd5;
        tick();
        select_valid = 1'b0; item_code = '0; restock_valid = 1'b0; restock_code = '0;
        settle("restock_tie");
        for (int i = 0; i < 3; i++) begin
            put_coin(55, 1'b0);
            do_sel(5, 1'b0, 0);
            settle("restock_tie_vend");
        end
    endtask

    task automatic test_cancel();
        do_cancel();
        total++;
        if (busy !== 1'b0 || change_valid !== 1'b0) begin
            bad++; $display("FAIL cancel_idle: got busy=%0b cv=%0b want 0/0", busy, change_valid);
        end
        put_coin(50, 1'b0); put_coin(10, 1'b0); put_coin(5, 1'b0); put_coin(1, 1'b0);
        total++;
        if (credit !== 8'd66) begin bad++; $display("FAIL cancel_credit: got %0d want 66", credit); end
        change_ready = 1'b0;
        do_cancel();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (change_valid !== 1'b1 || change_coin !== 8'd50 || credit !== 8'd66) begin
                bad++; $display("FAIL cancel_hold%0d: got cv=%0b coin=%0d credit=%0d want 1/50/66",
                                k, change_valid, change_coin, credit);
            end
            if (k == 1) begin select_valid = 1'b1; item_code = 4'd1; end
            tick();
            select_valid = 1'b0; item_code = '0;
        end
        exp_chg_q.push_back(50); exp_chg_q.push_back(10); exp_chg_q.push_back(5); exp_chg_q.push_back(1);
        change_ready = 1'b1;
        put_coin(10, 1'b1);
        settle("cancel_payout");
        total++;
        if (credit !== 8'd0 || change_valid !== 1'b0) begin
            bad++; $display("FAIL cancel_end: got credit=%0d cv=%0b want 0/0", credit, change_valid);
        end
        change_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        change_ready = 1'b1;
        put_coin(20, 1'b0);
        // Select and coin together: select wins, coin bounced, 10 returned
        exp_disp_q.push_back(1); exp_rej_q.push_back(1); exp_chg_q.push_back(10);
        select_valid = 1'b1; item_code = 4'd1; coin_valid = 1'b1; coin_value = 8'd5;
        tick();
        select_valid = 1'b0; item_code = '0; coin_valid = 1'b0; coin_value = '0;
        total++;
        if (credit !== 8'd10) begin bad++; $display("FAIL b2b_credit: got %0d want 10", credit); end
        settle("b2b");
        put_coin(40, 1'b0);
        do_sel(4, 1'b0, 0);
        tick();
        put_coin(15, 1'b0);
        do_sel(2, 1'b0, 0);
        settle("b2b_second");
        total++;
        if (credit !== 8'd0 || dispense_code !== 4'd2) begin
            bad++; $display("FAIL b2b_end: got credit=%0d code=%0d want 0/2", credit, dispense_code);
        end
        change_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_errors();
        test_stock_reset();
        test_restock();
        test_cancel();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vending_machine_ctrl.md
# vending_machine_ctrl

Parametrised vending-machine controller. Accumulates credit from a coin handshake and checks a selection against a price table and per-item stock counters. Issues a one-cycle dispense pulse, then pays out remaining credit as a stream of coins under backpressure. Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

## Interface
- AMT_W, 8, credit/price/coin width; maximum credit is 2^AMT_W-1
- NUM_ITEMS, 10, item slots; valid codes are 1..NUM_ITEMS
- CODE_W, 4, item code width; must satisfy 2^CODE_W > NUM_ITEMS
- STOCK_W, 4, per-item stock counter width
- INIT_STOCK, 3, stock of every slot after reset; must be ≤ 2^STOCK_W-1
- clk  in  1  clock, all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- coin_valid  in  1  coin presented this cycle
- coin_value  in  AMT_W  coin value
- select_valid  in  1  selection presented this cycle
- item_code  in  CODE_W  selected item
- cancel  in  1  refund request
- restock_valid  in  1  refill one slot
- restock_code  in  CODE_W  slot to refill to 2^STOCK_W-1
- change_ready  in  1  hopper accepts a change coin
- credit  out  AMT_W  current credit
- dispense  out  1  one-cycle vend pulse
- dispense_code  out  CODE_W  item vended; holds its last value
- change_valid  out  1  change coin offered
- change_coin  out  AMT_W  coin value: 50, 10, 5 or 1
- coin_reject  out  1  one-cycle pulse; coin not credited
- err  out  1  one-cycle pulse; selection refused
- err_code  out  2  01 bad code, 10 sold out, 11 insufficient credit
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit 0), CREDIT, VEND, CHANGE.
- Coin accepted in IDLE or CREDIT when credit+coin_value ≤ 2^AMT_W-1 (sum computed at AMT_W+1 bits).
  - On acceptance credit increases and the state goes to CREDIT.
  - Otherwise coin_reject pulses. coin_value 0 is accepted with no effect.
- Coins arriving in VEND or CHANGE are rejected.
- Priority within one cycle: cancel > select > coin. A coin lost to a higher-priority request is rejected.
- Select in IDLE or CREDIT:
  - code 0 or > NUM_ITEMS: err, err_code 01.
  - stock 0: err, err_code 10.
  - credit < price: err, err_code 11.
  - In all error cases credit is kept and the state is unchanged.
  - Otherwise: go to VEND, credit -= price, stock[code] -= 1, latch dispense_code.
- VEND lasts one cycle and asserts dispense. It then goes to CHANGE if credit > 0, else IDLE.
- Cancel in CREDIT goes to CHANGE. Cancel in IDLE, VEND or CHANGE is ignored.
- CHANGE:
  - change_coin is the largest of {50,10,5,1} ≤ credit. change_valid stays high and change_coin stays stable until change_ready.
  - On each change_valid && change_ready, credit -= change_coin.
  - When credit reaches 0, go to IDLE. change_valid is low in that cycle.
  - Selects in CHANGE are ignored with no err.
- Restock applies in any state. If it coincides with a vend of the same slot, restock wins.
- Reset mid-operation clears everything: credit is lost and stock returns to INIT_STOCK.

## Timing
- Reset values: credit 0, dispense 0, dispense_code 0, change_valid 0, change_coin 0, coin_reject 0, err 0, err_code 00, busy 0, state IDLE.
- All outputs are registered.
- Coin to credit update: 1 cycle. coin_reject pulses in the same cycle as the credit update would have occurred.
- Select to dispense: 1 cycle. The err pulse also comes 1 cycle after select.
- dispense is followed by the first change_valid on the next cycle.
- Change payout of N coins with change_ready held high takes N cycles.
- err_code is valid only while err is high. Otherwise it is 00.

## Structure
- Package vending_pkg holds:
  - state enum.
  - err_code constants.
  - Denomination constants 50/10/5/1.
  - Function price(code): 10,15,25,40,55,70,90,120,150,200 for codes 1..10, 0 otherwise.
- One sub-module, change_dispenser: the payout handshake and greedy denomination select, owning credit decrement in CHANGE.

## Test plan
- Reset low mid-CREDIT with credit 40 → all outputs at reset values asynchronously; stock back to 3.
- Coins 10, 5 → credit 15; select 2 → dispense with dispense_code 2 next cycle, credit 0, return to IDLE, no change_valid.
- Coins 50, 50, 50, 5 (credit 155); select 8 (price 120) → dispense, then change coins 10, 10, 10, 5 with change_ready high; credit 0.
- Credit 250 plus a coin of 10 → coin_reject, credit stays 250. Select 0 → err 01. Select 9 with credit 100 → err 11, credit 100.
- Vend item 1 three times (INIT_STOCK 3); fourth select → err 10. Restock 1, then select → dispense.
- Cancel with credit 66, change_ready low for 3 cycles → change_coin 50 held stable. Then ready → coins 50, 10, 5, 1; a coin inserted during payout → coin_reject.
